wb_arbiter2: RTL
================

# wb_arbiter2

Two-master, one-slave Wishbone arbiter that shares the system bus (boot ROM/SRAM decode fabric) between the picorv32 core and a second bus master (DMA or debug bridge). Grants are round-robin and held for a whole Wishbone cycle (`cyc` asserted). A per-transfer watchdog terminates stalled accesses with `err` so a missing slave cannot hang either master. Sits between the masters and the existing address decoder.

## Interface
- `AW`, default 32, address width.
- `DW`, default 32, data width; `SW = DW/8` select width.
- `TIMEOUT`, default 255, watchdog limit in cycles, legal range 1..65535.

Ports (`mN_` means one port each for `m0_` and `m1_`):
- `wb_clk_i`  input  1  single bus clock.
- `wb_reset_i`  input  1  reset, asynchronous, active-high.
- `mN_wb_adr_i`  input  AW  master address.
- `mN_wb_dat_i`  input  DW  master write data.
- `mN_wb_dat_o`  output  DW  read data to master.
- `mN_wb_we_i` / `mN_wb_sel_i` / `mN_wb_cyc_i` / `mN_wb_stb_i`  input  1/SW/1/1  master control.
- `mN_wb_ack_o` / `mN_wb_err_o`  output  1/1  termination to master.
- `s_wb_adr_o` / `s_wb_dat_o` / `s_wb_we_o` / `s_wb_sel_o` / `s_wb_cyc_o` / `s_wb_stb_o`  output  AW/DW/1/SW/1/1  muxed request to slave side.
- `s_wb_dat_i` / `s_wb_ack_i` / `s_wb_err_i`  input  DW/1/1  slave response.
- `gnt_o`  output  2  one-hot current grant; 2'b00 when idle.

## Operation
- States: IDLE, GNT0, GNT1. Registered `last` pointer holds the master served most recently; reset value 1, so m0 wins the first contention.
- IDLE: only m0 `cyc` → GNT0; only m1 `cyc` → GNT1; both → master != `last`; neither → stay.
- GNTn: slave outputs are a combinational mux of master n's request. `s_wb_dat_i` goes to both `dat_o` ports; `ack`/`err` go only to master n, the other master sees 0.
- GNTn exits to IDLE on the edge after master n drops `cyc`; `last` <= n on that edge. The grant is never pre-empted while `cyc` is held.
- IDLE and reset: `s_wb_cyc_o` = `s_wb_stb_o` = 0, all `ack`/`err` = 0, `gnt_o` = 0. Address, data, we and sel outputs follow m0 (don't-care).
- Watchdog: 16-bit counter `wdt`.
  - Increments on each granted cycle with `stb` high and no `s_wb_ack_i`/`s_wb_err_i`.
  - Clears on ack, err, `stb` low, or any state change.
  - When `wdt` == TIMEOUT-1 and the stall continues, asserts granted master's `err_o` for that cycle. `s_wb_stb_o` is forced low that cycle and `wdt` clears.
- If the slave returns ack or err in the same cycle as the timeout, the slave response wins and no timeout err is generated.
- `ack_o` and `err_o` are never both high.

## Timing
- Arbitration latency 1 cycle: `cyc` rises in cycle k in IDLE → `s_wb_cyc_o` and `gnt_o` valid in cycle k+1.
- Data path is combinational while granted: slave ack in cycle j reaches the master in cycle j. Pipelined single-cycle slaves run at full rate.
- Handoff costs at least one IDLE cycle between grants, even when the other master is waiting.
- Timeout err appears in the TIMEOUT-th consecutive stalled cycle after `stb` rises (TIMEOUT=1 → err in first stalled cycle).
- Reset asserted mid-cycle: state → IDLE, `last` → 1, `wdt` → 0, and all slave/termination outputs drop asynchronously. After release, masters still holding `cyc` re-arbitrate from IDLE.
- Master dropping `cyc` without receiving ack: legal abort. The slave sees `cyc` low in the same cycle, and the release proceeds as normal.

## Test plan
- Single master: m0 reads 0x10000004, slave acks next cycle with 0xCAFEF00D → `gnt_o` = 01 one cycle after `cyc`; m0 gets `dat_o` = 0xCAFEF00D with ack; m1 `ack_o` stays 0.
- Contention: m0 and m1 assert `cyc` in the same cycle after reset → m0 granted first. On m0 release: one IDLE cycle, then `gnt_o` = 10. Repeat the simultaneous request → m0 again (alternation).
- Hold: m1 holds `cyc` across 3 back-to-back stb/ack transfers while m0 requests → m0 is not granted until cycle+1 after m1 drops `cyc`.
- Timeout: TIMEOUT=4, slave never acks m0 write to 0x20000000 → m0 `err_o` pulses in the 4th stall cycle with `s_wb_stb_o` low; no ack. Same-cycle slave ack instead → ack only.
- Reset mid-transfer: assert `wb_reset_i` while GNT1 with `stb` high → `s_wb_cyc_o`, `gnt_o` and m1 `ack_o` go 0 immediately. After release with both requesting → m0 granted.
- Abort: m0 drops `cyc` before ack → `s_wb_cyc_o` low the same cycle, IDLE next, `wdt` cleared.

Source files
------------

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter in front of a single slave port.
// The grant is held for a whole master cycle; a watchdog ends stalled strobes with err.
module wb_arbiter2 #(
  parameter int AW = 32,
  parameter int DW = 32,
  localparam int SW = DW / 8,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_reset_i,
  input  logic [AW-1:0] m0_wb_adr_i,
  input  logic [DW-1:0] m0_wb_dat_i,
  output logic [DW-1:0] m0_wb_dat_o,
  input  logic          m0_wb_we_i,
  input  logic [SW-1:0] m0_wb_sel_i,
  input  logic          m0_wb_cyc_i,
  input  logic          m0_wb_stb_i,
  output logic          m0_wb_ack_o,
  output logic          m0_wb_err_o,
  input  logic [AW-1:0] m1_wb_adr_i,
  input  logic [DW-1:0] m1_wb_dat_i,
  output logic [DW-1:0] m1_wb_dat_o,
  input  logic          m1_wb_we_i,
  input  logic [SW-1:0] m1_wb_sel_i,
  input  logic          m1_wb_cyc_i,
  input  logic          m1_wb_stb_i,
  output logic          m1_wb_ack_o,
  output logic          m1_wb_err_o,
  output logic [AW-1:0] s_wb_adr_o,
  output logic [DW-1:0] s_wb_dat_o,
  output logic          s_wb_we_o,
  output logic [SW-1:0] s_wb_sel_o,
  output logic          s_wb_cyc_o,
  output logic          s_wb_stb_o,
  input  logic [DW-1:0] s_wb_dat_i,
  input  logic          s_wb_ack_i,
  input  logic          s_wb_err_i,
  output logic [1:0]    gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam logic [15:0] WDT_LIMIT = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] wdt_q, wdt_d;

  logic sel_m1;
  logic granted;
  logic req_cyc;
  logic req_stb;
  logic stalled;
  logic timeout;
  logic term_ack;
  logic term_err;

  // Granted master's request and the watchdog stall/timeout condition.
  always_comb begin
    sel_m1  = (state_q == GNT1);
    granted = (state_q != IDLE);
    req_cyc = sel_m1 ? m1_wb_cyc_i : m0_wb_cyc_i;
    req_stb = sel_m1 ? m1_wb_stb_i : m0_wb_stb_i;
    stalled = granted & req_cyc & req_stb & ~s_wb_ack_i & ~s_wb_err_i;
    timeout = stalled & (wdt_q == WDT_LIMIT);
  end

  // Arbitration, release bookkeeping and watchdog count.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wdt_d   = 16'd0;
    case (state_q)
      IDLE: begin
        // On contention the master not served last wins; last_q resets to 1 so m0 goes first.
        if (m0_wb_cyc_i && (!m1_wb_cyc_i || last_q)) begin
          state_d = GNT0;
        end else if (m1_wb_cyc_i) begin
          state_d = GNT1;
        end else begin
          state_d = IDLE;
        end
      end
      GNT0: begin
        if (!m0_wb_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (stalled && !timeout) begin
          wdt_d = wdt_q + 16'd1;
        end else begin
          wdt_d = 16'd0;
        end
      end
      GNT1: begin
        if (!m1_wb_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end else if (stalled && !timeout) begin
          wdt_d = wdt_q + 16'd1;
        end else begin
          wdt_d = 16'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slave-side mux and termination routing; all of it collapses when the state leaves a grant.
  always_comb begin
    s_wb_adr_o  = sel_m1 ? m1_wb_adr_i : m0_wb_adr_i;
    s_wb_dat_o  = sel_m1 ? m1_wb_dat_i : m0_wb_dat_i;
    s_wb_we_o   = sel_m1 ? m1_wb_we_i  : m0_wb_we_i;
    s_wb_sel_o  = sel_m1 ? m1_wb_sel_i : m0_wb_sel_i;
    s_wb_cyc_o  = granted & req_cyc;
    s_wb_stb_o  = granted & req_stb & ~timeout;
    m0_wb_dat_o = s_wb_dat_i;
    m1_wb_dat_o = s_wb_dat_i;
    // A slave ack outranks its own err so the two terminations stay exclusive.
    term_ack    = granted & s_wb_ack_i;
    term_err    = granted & ((s_wb_err_i & ~s_wb_ack_i) | timeout);
    m0_wb_ack_o = term_ack & ~sel_m1;
    m0_wb_err_o = term_err & ~sel_m1;
    m1_wb_ack_o = term_ack & sel_m1;
    m1_wb_err_o = term_err & sel_m1;
    gnt_o       = {sel_m1, granted & ~sel_m1};
  end

  // State, round-robin pointer and watchdog registers.
  always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wdt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdt_q   <= wdt_d;
    end
  end

endmodule
